// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
//   Shared constants for the elastic pipelined multiplier.
//   - Legal range of the pipeline depth.
//   - Widths of the two beat records moving through the pipe:
//       operand record : {signed, tag, a, b}  (held by slice 0)
//       product record : {tag, product}       (held by slices 1..N-1)
//   The signed flag is consumed by the multiply between slices 0 and 1.
//   No slice after that needs it, so the product record does not carry it.
// ---------------------------------------------------------------------------
package mult_pkg;

   localparam int MULT_MIN_STAGES = 2;
   localparam int MULT_MAX_STAGES = 8;
   localparam int MULT_SIGN_W     = 1;

   // Operand record: sign-mode bit, tag, operand A, operand B.
   function automatic int mult_opnd_rec_w(input int data_w, input int tag_w);
      return MULT_SIGN_W + tag_w + 2 * data_w;
   endfunction

   // Product record: tag, full-width product.
   function automatic int mult_prod_rec_w(input int data_w, input int tag_w);
      return tag_w + 2 * data_w;
   endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// ---------------------------------------------------------------------------
// mult_pipe_stage
//   Elastic register slice: one valid bit plus a payload register.
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset (clears valid and payload)
//     i_advance  slice may take a new beat this cycle (empty or downstream
//                is advancing); computed by the owner of the chain
//     i_valid    upstream beat valid
//     i_data     upstream payload
//     o_valid    slice holds a valid beat
//     o_data     held payload
//   The payload only loads on a real beat, so a bubble passing through
//   never disturbs the data visible downstream.
// ---------------------------------------------------------------------------
module mult_pipe_stage
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_advance,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_advance) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/multiplier_pipe.sv
// ---------------------------------------------------------------------------
// multiplier_pipe
//   Elastic pipelined multiplier with per-beat signed/unsigned mode, a
//   sideband tag, full valid/ready backpressure and bubble collapsing.
//   Slice 0 registers operands, the multiply sits between slice 0 and
//   slice 1, and slices 2..PIPE_STAGES-1 are plain delay slices.
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     in_valid/in_ready     operand handshake
//     in_a, in_b            operands (DATA_WIDTH each)
//     in_signed             1: two's complement operands, 0: unsigned
//     in_tag                sideband tag returned with the product
//     out_valid/out_ready   product handshake
//     out_prod              2*DATA_WIDTH product
//     out_tag               tag of this product
//     busy                  any slice holds a valid beat
// ---------------------------------------------------------------------------
module multiplier_pipe
   import mult_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int PIPE_STAGES = 3,
   parameter int TAG_WIDTH   = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_a,
   input  logic [DATA_WIDTH-1:0]   in_b,
   input  logic                    in_signed,
   input  logic [TAG_WIDTH-1:0]    in_tag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*DATA_WIDTH-1:0] out_prod,
   output logic [TAG_WIDTH-1:0]    out_tag,
   output logic                    busy
);

   localparam int OW = mult_opnd_rec_w(DATA_WIDTH, TAG_WIDTH);
   localparam int PW = mult_prod_rec_w(DATA_WIDTH, TAG_WIDTH);

   generate
      if (PIPE_STAGES < MULT_MIN_STAGES || PIPE_STAGES > MULT_MAX_STAGES) begin : g_bad_depth
         $fatal(1, "multiplier_pipe: PIPE_STAGES=%0d outside %0d..%0d",
                PIPE_STAGES, MULT_MIN_STAGES, MULT_MAX_STAGES);
      end
   endgenerate

   logic [PIPE_STAGES-1:0] w_valid;
   logic [PIPE_STAGES-1:0] w_adv;

   // A slice advances if it is empty or everything after it advances.
   // Unrolled as a running OR from the output end: slice k advances when
   // out_ready is high or any slice j >= k is empty. This is what collapses
   // bubbles under a stall.
   always_comb begin
      logic w_run;
      w_run = out_ready;
      w_adv = '0;
      for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
         w_run    = w_run | ~w_valid[k];
         w_adv[k] = w_run;
      end
   end

   // ---- slice 0: operand record ----
   logic [OW-1:0]         w_s0_data;
   logic                  w_s0_signed;
   logic [TAG_WIDTH-1:0]  w_s0_tag;
   logic [DATA_WIDTH-1:0] w_s0_a;
   logic [DATA_WIDTH-1:0] w_s0_b;

   mult_pipe_stage #(.WIDTH(OW)) u_stage0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_advance (w_adv[0]),
      .i_valid   (in_valid),
      .i_data    ({in_signed, in_tag, in_a, in_b}),
      .o_valid   (w_valid[0]),
      .o_data    (w_s0_data)
   );

   assign {w_s0_signed, w_s0_tag, w_s0_a, w_s0_b} = w_s0_data;

   // ---- multiply between slice 0 and slice 1 ----
   // Extending both operands to 2W and keeping the low 2W bits of the
   // product gives the exact signed or unsigned result.
   logic [2*DATA_WIDTH-1:0] w_ext_a;
   logic [2*DATA_WIDTH-1:0] w_ext_b;
   logic [2*DATA_WIDTH-1:0] w_prod;

   assign w_ext_a = w_s0_signed ? {{DATA_WIDTH{w_s0_a[DATA_WIDTH-1]}}, w_s0_a}
                                : {{DATA_WIDTH{1'b0}}, w_s0_a};
   assign w_ext_b = w_s0_signed ? {{DATA_WIDTH{w_s0_b[DATA_WIDTH-1]}}, w_s0_b}
                                : {{DATA_WIDTH{1'b0}}, w_s0_b};
   assign w_prod  = w_ext_a * w_ext_b;

   // ---- slices 1..PIPE_STAGES-1: product record ----
   logic [PW-1:0] w_data [1:PIPE_STAGES-1];

   genvar gi;
   generate
      for (gi = 1; gi < PIPE_STAGES; gi++) begin : g_stage
         logic [PW-1:0] w_in;
         if (gi == 1) begin : g_first
            assign w_in = {w_s0_tag, w_prod};
         end else begin : g_delay
            assign w_in = w_data[gi-1];
         end

         mult_pipe_stage #(.WIDTH(PW)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_advance (w_adv[gi]),
            .i_valid   (w_valid[gi-1]),
            .i_data    (w_in),
            .o_valid   (w_valid[gi]),
            .o_data    (w_data[gi])
         );
      end
   endgenerate

   assign in_ready            = w_adv[0];
   assign out_valid           = w_valid[PIPE_STAGES-1];
   assign {out_tag, out_prod} = w_data[PIPE_STAGES-1];
   assign busy                = |w_valid;

endmodule
